tdm_slot_scheduler: RTL and testbench

Time-division scheduler that shares one resource among N_REQ requesters using a modulus-N slot pointer and a per-slot cycle timer. Each slot belongs to one requester. The owner is granted only if it is requesting when its slot opens, and it holds the grant until it signals completion or the slot times out. The block sits between the requester bank and the shared unit and is the sole source of grant.

---
 rtl/tdm_slot_scheduler_pkg.sv | 20 ++
 rtl/tdm_slot_scheduler_if.sv | 31 +++
 rtl/tdm_slot_scheduler_mod_n_counter.sv | 40 ++++
 rtl/tdm_slot_scheduler.sv | 144 ++++++++++++++
 tb/tb_tdm_slot_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_slot_scheduler_pkg.sv
// tdm_sched_pkg: shared definitions for the TDM slot scheduler.
//   state_e      - scheduler FSM states (IDLE, ARB, OWN, PAD)
//   MIN_SLOT_LEN - smallest legal slot length (arbitration cycle + one grant cycle)
//   cnt_width()  - counter width for a modulus-n count, never below 1 bit
package tdm_sched_pkg;

    localparam int MIN_SLOT_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_OWN  = 2'd2,
        ST_PAD  = 2'd3
    } state_e;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_scheduler_if.sv
// tdm_slot_scheduler_if: requester-bank <-> scheduler signal bundle.
//   en, req, done          - from the requester bank (master drives)
//   gnt, slot, busy, wrap,
//   timeout                - from the scheduler (slave drives)
interface tdm_slot_scheduler_if #(
    parameter int N_REQ = 6
);
    import tdm_sched_pkg::*;

    localparam int SW = cnt_width(N_REQ);

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [SW-1:0]    slot;
    logic             busy;
    logic             wrap;
    logic             timeout;

    modport master (
        output en, req, done,
        input  gnt, slot, busy, wrap, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, slot, busy, wrap, timeout
    );

endinterface

// File: rtl/tdm_slot_scheduler_mod_n_counter.sv
// mod_n_counter: counts 0..N-1 and wraps to 0.
//   clk, rst - clock, asynchronous active-high reset (count -> 0)
//   clr      - synchronous clear, wins over inc
//   inc      - advance by one (wraps after N-1)
//   cnt      - current count
//   at_max   - count is N-1; at_max & inc marks a wrap
module mod_n_counter
    import tdm_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [cnt_width(N)-1:0] cnt,
    output logic                    at_max
);
    localparam int            W   = cnt_width(N);
    localparam logic [W-1:0]  MAX = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == MAX);
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: time-division grant of one shared unit to N_REQ
// requesters. Slot k belongs to requester k; its owner is granted only if
// requesting in the slot's first (arbitration) cycle and keeps the grant
// until done[k] or slot expiry.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of tdm_slot_scheduler_if (en/req/done in,
//              gnt/slot/busy/wrap/timeout out; all outputs registered
//              except busy, which decodes the state register)
// Build option: define SKIP_IDLE_EN for work-conserving mode (empty slots
// cost one cycle, done ends the slot immediately).
module tdm_slot_scheduler
    import tdm_sched_pkg::*;
#(
    parameter int N_REQ    = 6,
    parameter int SLOT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tdm_slot_scheduler_if.slave  bus
);
    localparam int SW = cnt_width(N_REQ);
    localparam int TW = cnt_width(SLOT_LEN);

    if (SLOT_LEN < MIN_SLOT_LEN) begin : g_bad_slot_len
        $error("tdm_slot_scheduler: SLOT_LEN below minimum");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("tdm_slot_scheduler: N_REQ out of range 2..16");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             wrap_q, wrap_d;
    logic             timeout_q, timeout_d;

    logic [SW-1:0]    slot;
    logic             slot_max;
    logic [TW-1:0]    tmr;
    logic             tmr_max, tmr_clr, tmr_inc;
    logic             slot_end;
    logic             req_cur, done_cur;

    // Only the current slot owner's request/done are ever looked at.
    assign req_cur  = bus.req[slot];
    assign done_cur = bus.done[slot];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        wrap_d    = 1'b0;
        timeout_d = 1'b0;
        slot_end  = 1'b0;
        tmr_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_ARB;
                    tmr_clr = 1'b1;
                end
            end
            ST_ARB: begin
                if (req_cur) begin
                    state_d     = ST_OWN;
                    gnt_d       = '0;
                    gnt_d[slot] = 1'b1;
                end else begin
`ifdef SKIP_IDLE_EN
                    slot_end = 1'b1;
`else
                    state_d  = ST_PAD;
`endif
                end
            end
            ST_OWN: begin
                // done wins over a coincident expiry: no timeout pulse.
                if (done_cur) begin
                    gnt_d = '0;
`ifdef SKIP_IDLE_EN
                    slot_end = 1'b1;
`else
                    if (tmr_max) slot_end = 1'b1;
                    else         state_d  = ST_PAD;
`endif
                end else if (tmr_max) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    slot_end  = 1'b1;
                end
            end
            ST_PAD: begin
                if (tmr_max) slot_end = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // en is only consulted here, so dropping it mid-slot lets the slot finish.
        if (slot_end) begin
            state_d = bus.en ? ST_ARB : ST_IDLE;
            tmr_clr = 1'b1;
            wrap_d  = slot_max;
        end
    end

    assign tmr_inc = (state_q != ST_IDLE) && !tmr_clr;

    mod_n_counter #(.N(N_REQ)) u_slot_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .inc    (slot_end),
        .cnt    (slot),
        .at_max (slot_max)
    );

    mod_n_counter #(.N(SLOT_LEN)) u_tmr_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .cnt    (tmr),
        .at_max (tmr_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            wrap_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wrap_q    <= wrap_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.slot    = slot;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.wrap    = wrap_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Testbench for tdm_slot_scheduler (N_REQ=6, SLOT_LEN=4). Honours
// SKIP_IDLE_EN when the design is built with it.
module tb_tdm_slot_scheduler;
    localparam int N  = 6;
    localparam int L  = 4;
    localparam int SW = 3;
    localparam int VW = N + SW + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_slot_scheduler_if #(.N_REQ(N)) bus ();

    tdm_slot_scheduler #(.N_REQ(N), .SLOT_LEN(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: where we are inside the current slot, in slot-level terms.
    int m_slot, m_k;
    bit m_busy, m_gnt, m_wrap, m_to;

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_gnt) g[m_slot] = 1'b1;
        return {g, SW'(m_slot), m_busy, m_wrap, m_to};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.gnt, bus.slot, bus.busy, bus.wrap, bus.timeout};
    endfunction

    task automatic model_reset();
        m_slot = 0; m_k = 0; m_busy = 0; m_gnt = 0; m_wrap = 0; m_to = 0;
    endtask

    // One rising edge; model advances from the inputs seen at that edge.
    task automatic step();
        bit end_slot;
        bit skip;
`ifdef SKIP_IDLE_EN
        skip = 1;
`else
        skip = 0;
`endif
        @(posedge clk);
        m_wrap = 0; m_to = 0; end_slot = 0;
        if (!m_busy) begin
            if (bus.en) begin m_busy = 1; m_k = 0; end
        end else begin
            if (m_k == 0) begin
                if (bus.req[m_slot]) m_gnt = 1;
                else if (skip) end_slot = 1;
            end else if (m_gnt) begin
                if (bus.done[m_slot]) begin
                    m_gnt = 0;
                    if (skip || m_k == L - 1) end_slot = 1;
                end else if (m_k == L - 1) begin
                    m_gnt = 0; m_to = 1; end_slot = 1;
                end
            end else if (m_k == L - 1) begin
                end_slot = 1;
            end
            if (end_slot) begin
                m_wrap = (m_slot == N - 1);
                m_slot = (m_slot + 1) % N;
                m_k    = 0;
                m_busy = bus.en;
            end else begin
                m_k++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.req = '0; bus.done = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.req = '0; bus.done = '0;
        model_reset();
        #1;
        n_tests++;
        if (act_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", act_vec());
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (act_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h want 0", act_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_single_owner();
        logic [VW-1:0] want;
        do_reset();
        bus.en = 1'b1; bus.req = 6'b000001;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1)      want = {6'b000000, 3'd0, 1'b1, 1'b0, 1'b0};
            else if (c <= 4) want = {6'b000001, 3'd0, 1'b1, 1'b0, 1'b0};
            else             want = {6'b000000, 3'd1, 1'b1, 1'b0, 1'b1};
            n_tests++;
            if (act_vec() !== want) begin
                n_fail++;
                $display("FAIL single_owner_c%0d: got %h want %h", c, act_vec(), want);
            end
        end
    endtask

    task automatic test_done_pad();
        int n, extra;
        do_reset();
        bus.en = 1'b1; bus.req = 6'b000100;
        n = 0;
        while (bus.slot !== 3'd2 && n < 100) begin step(); n++; end
        n_tests++;
        if (n >= 100) begin n_fail++; $display("FAIL done_pad_reach: slot %0d want 2", bus.slot); end
        step();
        step();
        n_tests++;
        if (bus.gnt !== 6'b000100) begin
            n_fail++;
            $display("FAIL done_pad_grant: gnt %b want 000100", bus.gnt);
        end
        bus.done = 6'b000100;
        step();
        bus.done = '0;
        n_tests++;
        if (bus.gnt !== 6'b000000 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pad_drop: gnt %b to %b want 000000 0", bus.gnt, bus.timeout);
        end
        extra = 0;
        while (bus.slot !== 3'd3 && extra < 10) begin step(); extra++; end
        n_tests++;
`ifdef SKIP_IDLE_EN
        if (3 + extra !== 3) begin
`else
        if (3 + extra !== 4) begin
`endif
            n_fail++;
            $display("FAIL done_pad_slot_len: slot 3 opened after %0d cycles", 3 + extra);
        end
    endtask

    task automatic test_idle_rotation();
        int per, ticks, wraps, first_wrap, want_slot;
`ifdef SKIP_IDLE_EN
        per = 1;
`else
        per = L;
`endif
        ticks = 2 * N * per + 1;
        wraps = 0; first_wrap = -1;
        do_reset();
        bus.en = 1'b1;
        for (int t = 1; t <= ticks; t++) begin
            step();
            want_slot = ((t - 1) / per) % N;
            n_tests++;
            if (bus.slot !== SW'(want_slot) || act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_t%0d: got %h model %h slot want %0d",
                         t, act_vec(), exp_vec(), want_slot);
            end
            if (bus.wrap === 1'b1) begin
                wraps++;
                if (first_wrap < 0) first_wrap = t;
            end
        end
        n_tests++;
        if (wraps !== 2 || first_wrap !== N * per + 1) begin
            n_fail++;
            $display("FAIL rotation_wrap: %0d wraps first at %0d want 2 at %0d",
                     wraps, first_wrap, N * per + 1);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        bus.en = 1'b1; bus.req = 6'b010000;
        n = 0;
        while (bus.gnt !== 6'b010000 && n < 100) begin step(); n++; end
        n_tests++;
        if (n >= 100) begin n_fail++; $display("FAIL async_reach: gnt %b want 010000", bus.gnt); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (act_vec() !== '0) begin
            n_fail++;
            $display("FAIL async_reset_own: got %h want 0", act_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_en_drop();
        int n;
        do_reset();
        bus.en = 1'b1; bus.req = 6'b000010;
        n = 0;
        while (bus.gnt !== 6'b000010 && n < 100) begin step(); n++; end
        bus.en = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin step(); n++; end
        n_tests++;
        if (n !== 3 || bus.slot !== 3'd2 || bus.gnt !== 6'b0 || bus.timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop_idle: after %0d cycles slot %0d gnt %b to %b want 3 2 000000 1",
                     n, bus.slot, bus.gnt, bus.timeout);
        end
        bus.req = '0;
        step(); step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.slot !== 3'd2) begin
            n_fail++;
            $display("FAIL en_drop_hold: busy %b slot %0d want 0 2", bus.busy, bus.slot);
        end
        bus.en = 1'b1;
        step();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.slot !== 3'd2 || bus.gnt !== 6'b0) begin
            n_fail++;
            $display("FAIL en_resume: busy %b slot %0d gnt %b want 1 2 000000",
                     bus.busy, bus.slot, bus.gnt);
        end
    endtask

    task automatic test_stray_done();
        int n;
        do_reset();
        bus.en = 1'b1; bus.req = 6'b000010;
        n = 0;
        while (bus.gnt !== 6'b000010 && n < 100) begin step(); n++; end
        bus.done = 6'b001000;
        for (int c = 2; c <= 3; c++) begin
            step();
            n_tests++;
            if (bus.gnt !== 6'b000010 || bus.timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_done_c%0d: gnt %b to %b want 000010 0", c, bus.gnt, bus.timeout);
            end
        end
        bus.done = 6'b001010;
        step();
        bus.done = '0;
        n_tests++;
        if (bus.gnt !== 6'b0 || bus.timeout !== 1'b0 || bus.slot !== 3'd2) begin
            n_fail++;
            $display("FAIL done_at_expiry: gnt %b to %b slot %0d want 000000 0 2",
                     bus.gnt, bus.timeout, bus.slot);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bus.en   = ($urandom_range(0, 7) != 0);
            bus.req  = N'($urandom);
            bus.done = N'($urandom & $urandom);
            step();
            n_tests++;
            if (act_vec() !== exp_vec() || !$onehot0(bus.gnt)) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_owner();
        test_done_pad();
        test_idle_rotation();
        test_async_reset();
        test_en_drop();
        test_stray_done();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
